// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: register indices, widths and the
// register-index type used by the decoder, write-back mux and register file.
package mips_pkg;

    localparam int REG_IDX_W = 5;
    localparam int DATA_W    = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;
    localparam reg_idx_t REG_RA   = 5'd31;

endpackage

// File: rtl/reg_read_port.sv
// Combinational register read port. Index 0 always reads zero; when BYPASS
// is set, a read of the register being written this cycle returns the
// incoming data, with the link write taking priority on the return-address
// register.
module reg_read_port #(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int DEPTH  = 32,
    parameter int IDX_W  = $clog2(DEPTH),
    parameter bit BYPASS = 1'b0
) (
    input  logic [DEPTH-1:0][DATA_W-1:0] i_regs,
    input  logic [IDX_W-1:0]             i_rdIdx,
    input  logic                         i_wrEn,
    input  logic [IDX_W-1:0]             i_wrIdx,
    input  logic [DATA_W-1:0]            i_wrData,
    input  logic                         i_linkEn,
    input  logic [DATA_W-1:0]            i_linkData,
    output logic [DATA_W-1:0]            o_data
);

    import mips_pkg::*;

    localparam logic [IDX_W-1:0] ZERO_IDX = IDX_W'(REG_ZERO);
    localparam logic [IDX_W-1:0] LINK_IDX = IDX_W'(REG_RA);

    // Select the stored value, optionally override with in-flight write data, then mask index 0
    always_comb begin
        o_data = i_regs[i_rdIdx];
        if (BYPASS) begin
            if (i_linkEn && i_rdIdx == LINK_IDX) begin
                o_data = i_linkData;
            end else if (i_wrEn && i_wrIdx == i_rdIdx) begin
                o_data = i_wrData;
            end
        end
        if (i_rdIdx == ZERO_IDX) begin
            o_data = '0;
        end
    end

endmodule

// File: rtl/reg_file.sv
// MIPS general-purpose register file: two operand read ports, one debug read
// port, one write-back port and a dedicated jal link write to $ra.
// Register 0 has no storage and always reads zero.
module reg_file #(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int DEPTH  = 32,
    parameter bit BYPASS = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [$clog2(DEPTH)-1:0]   read_reg_1,
    input  logic [$clog2(DEPTH)-1:0]   read_reg_2,
    output logic [DATA_W-1:0]          read_1,
    output logic [DATA_W-1:0]          read_2,
    input  logic                       reg_write,
    input  logic [$clog2(DEPTH)-1:0]   write_reg,
    input  logic [DATA_W-1:0]          write_data,
    input  logic                       link_we,
    input  logic [DATA_W-1:0]          link_data,
    input  logic [$clog2(DEPTH)-1:0]   dbg_reg,
    output logic [DATA_W-1:0]          dbg_data
);

    import mips_pkg::*;

    localparam int               IDX_W    = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LINK_IDX = IDX_W'(REG_RA);

    logic [DATA_W-1:0]             r_regs [1:DEPTH-1];
    logic [DEPTH-1:0][DATA_W-1:0]  w_regView;
    logic                          w_wrEn;
    logic                          w_linkEn;

    // Bypass must not leak write data onto the read ports while in reset
    assign w_wrEn   = reg_write & rst_n;
    assign w_linkEn = link_we & rst_n;

    // Flatten storage into a read view with a constant zero in slot 0
    always_comb begin
        w_regView[0] = '0;
        for (int i = 1; i < DEPTH; i++) begin
            w_regView[i] = r_regs[i];
        end
    end

    // Register writes: link write owns $ra when active, write-back otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (link_we && IDX_W'(i) == LINK_IDX) begin
                    r_regs[i] <= link_data;
                end else if (reg_write && write_reg == IDX_W'(i)) begin
                    r_regs[i] <= write_data;
                end
            end
        end
    end

    reg_read_port #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W),
        .BYPASS (BYPASS)
    ) u_readRs (
        .i_regs     (w_regView),
        .i_rdIdx    (read_reg_1),
        .i_wrEn     (w_wrEn),
        .i_wrIdx    (write_reg),
        .i_wrData   (write_data),
        .i_linkEn   (w_linkEn),
        .i_linkData (link_data),
        .o_data     (read_1)
    );

    reg_read_port #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W),
        .BYPASS (BYPASS)
    ) u_readRt (
        .i_regs     (w_regView),
        .i_rdIdx    (read_reg_2),
        .i_wrEn     (w_wrEn),
        .i_wrIdx    (write_reg),
        .i_wrData   (write_data),
        .i_linkEn   (w_linkEn),
        .i_linkData (link_data),
        .o_data     (read_2)
    );

    // The debug port always shows committed state only
    reg_read_port #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W),
        .BYPASS (1'b0)
    ) u_readDbg (
        .i_regs     (w_regView),
        .i_rdIdx    (dbg_reg),
        .i_wrEn     (w_wrEn),
        .i_wrIdx    (write_reg),
        .i_wrData   (write_data),
        .i_linkEn   (w_linkEn),
        .i_linkData (link_data),
        .o_data     (dbg_data)
    );

endmodule

// File: tb/tb_reg_file.sv
// Testbench for reg_file: one instance without bypass, one with bypass,
// both driven by the same stimulus and compared against an array model.
module tb_reg_file;

    import mips_pkg::*;

    logic        clk;
    logic        rst_n;
    reg_idx_t    readReg1;
    reg_idx_t    readReg2;
    reg_idx_t    writeReg;
    reg_idx_t    dbgReg;
    logic        regWrite;
    logic [31:0] writeData;
    logic        linkWe;
    logic [31:0] linkData;

    logic [31:0] read1A, read2A, dbgA;
    logic [31:0] read1B, read2B, dbgB;

    logic [31:0] model [32];
    int          checks;
    int          errors;

    typedef struct {
        string       name;
        logic        regWrite;
        logic [4:0]  writeReg;
        logic [31:0] writeData;
        logic        linkWe;
        logic [31:0] linkData;
        logic [4:0]  rd1;
        logic [4:0]  rd2;
        logic [4:0]  dbg;
        logic [31:0] exp1;
        logic [31:0] exp2;
        logic [31:0] expDbg;
    } vec_t;

    vec_t vecs [7];

    reg_file #(.BYPASS(1'b0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .read_reg_1 (readReg1),
        .read_reg_2 (readReg2),
        .read_1     (read1A),
        .read_2     (read2A),
        .reg_write  (regWrite),
        .write_reg  (writeReg),
        .write_data (writeData),
        .link_we    (linkWe),
        .link_data  (linkData),
        .dbg_reg    (dbgReg),
        .dbg_data   (dbgA)
    );

    reg_file #(.BYPASS(1'b1)) dutByp (
        .clk        (clk),
        .rst_n      (rst_n),
        .read_reg_1 (readReg1),
        .read_reg_2 (readReg2),
        .read_1     (read1B),
        .read_2     (read2B),
        .reg_write  (regWrite),
        .write_reg  (writeReg),
        .write_data (writeData),
        .link_we    (linkWe),
        .link_data  (linkData),
        .dbg_reg    (dbgReg),
        .dbg_data   (dbgB)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Architectural value of a register as seen after all committed writes
    function automatic logic [31:0] storedVal(input int idx);
        if (idx == 0) return 32'h0;
        return model[idx];
    endfunction

    // Value a forwarding read port should show given the pending write this cycle
    function automatic logic [31:0] bypassVal(input int idx);
        if (idx != 0 && rst_n) begin
            if (linkWe && idx == 31) return linkData;
            if (regWrite && int'(writeReg) == idx) return writeData;
        end
        return storedVal(idx);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic rw, input logic [4:0] wr, input logic [31:0] wd,
                                 input logic lw, input logic [31:0] ld,
                                 input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] dg);
        regWrite  = rw;
        writeReg  = wr;
        writeData = wd;
        linkWe    = lw;
        linkData  = ld;
        readReg1  = r1;
        readReg2  = r2;
        dbgReg    = dg;
        #1;
    endtask

    // One rising edge; the model commits what the inputs request, link last so it wins
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            if (regWrite && writeReg != 5'd0) model[writeReg] = writeData;
            if (linkWe) model[31] = linkData;
        end
        #1;
    endtask

    task automatic assertReset();
        rst_n = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    // Compare every port of both instances against the model for the current inputs
    task automatic checkAgainstModel(input string tag);
        checkOutput({tag, " A rs"},  read1A, storedVal(int'(readReg1)));
        checkOutput({tag, " A rt"},  read2A, storedVal(int'(readReg2)));
        checkOutput({tag, " A dbg"}, dbgA,   storedVal(int'(dbgReg)));
        checkOutput({tag, " B rs"},  read1B, bypassVal(int'(readReg1)));
        checkOutput({tag, " B rt"},  read2B, bypassVal(int'(readReg2)));
        checkOutput({tag, " B dbg"}, dbgB,   storedVal(int'(dbgReg)));
    endtask

    // Every index on every port of both instances must read zero
    task automatic sweepZero(input string tag, input logic pendingWrites);
        for (int i = 0; i < 32; i++) begin
            applyStimulus(pendingWrites, 5'(i), 32'hCAFE_0000 | 32'(i), pendingWrites, 32'hBEEF_0000,
                          5'(i), 5'(31 - i), 5'(i));
            checkOutput($sformatf("%s A rs r%0d", tag, i),  read1A, 32'h0);
            checkOutput($sformatf("%s A rt r%0d", tag, 31 - i), read2A, 32'h0);
            checkOutput($sformatf("%s A dbg r%0d", tag, i), dbgA,   32'h0);
            checkOutput($sformatf("%s B rs r%0d", tag, i),  read1B, 32'h0);
            checkOutput($sformatf("%s B rt r%0d", tag, 31 - i), read2B, 32'h0);
            checkOutput($sformatf("%s B dbg r%0d", tag, i), dbgB,   32'h0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;

        vecs[0] = '{"write r8",      1'b1, 5'd8,  32'h0000_1234, 1'b0, 32'h0,
                    5'd8,  5'd8,  5'd8,  32'h0000_1234, 32'h0000_1234, 32'h0000_1234};
        vecs[1] = '{"write r0",      1'b1, 5'd0,  32'hFFFF_FFFF, 1'b0, 32'h0,
                    5'd0,  5'd8,  5'd0,  32'h0,         32'h0000_1234, 32'h0};
        vecs[2] = '{"link priority", 1'b1, 5'd31, 32'hAAAA_0000, 1'b1, 32'h0040_0008,
                    5'd31, 5'd0,  5'd31, 32'h0040_0008, 32'h0,         32'h0040_0008};
        vecs[3] = '{"dual write",    1'b1, 5'd5,  32'h0000_0011, 1'b1, 32'h0040_0010,
                    5'd5,  5'd31, 5'd5,  32'h0000_0011, 32'h0040_0010, 32'h0000_0011};
        vecs[4] = '{"write r9",      1'b1, 5'd9,  32'h0000_0022, 1'b0, 32'h0,
                    5'd9,  5'd5,  5'd9,  32'h0000_0022, 32'h0000_0011, 32'h0000_0022};
        vecs[5] = '{"no enable",     1'b0, 5'd9,  32'hDEAD_BEEF, 1'b0, 32'h1111_1111,
                    5'd9,  5'd31, 5'd9,  32'h0000_0022, 32'h0040_0010, 32'h0000_0022};
        vecs[6] = '{"plain r31",     1'b1, 5'd31, 32'h0000_1357, 1'b0, 32'h0,
                    5'd31, 5'd8,  5'd31, 32'h0000_1357, 32'h0000_1234, 32'h0000_1357};

        // Power-on reset: everything reads zero without any clock edge needed
        assertReset();
        sweepZero("por", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd0, 5'd0, 5'd0);
        tick();

        // Directed table: write on one edge, read back with writes idle
        foreach (vecs[k]) begin
            applyStimulus(vecs[k].regWrite, vecs[k].writeReg, vecs[k].writeData,
                          vecs[k].linkWe, vecs[k].linkData, vecs[k].rd1, vecs[k].rd2, vecs[k].dbg);
            tick();
            applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, vecs[k].rd1, vecs[k].rd2, vecs[k].dbg);
            checkOutput({vecs[k].name, " A rs"},  read1A, vecs[k].exp1);
            checkOutput({vecs[k].name, " A rt"},  read2A, vecs[k].exp2);
            checkOutput({vecs[k].name, " A dbg"}, dbgA,   vecs[k].expDbg);
            checkOutput({vecs[k].name, " B rs"},  read1B, vecs[k].exp1);
            checkOutput({vecs[k].name, " B rt"},  read2B, vecs[k].exp2);
            checkOutput({vecs[k].name, " B dbg"}, dbgB,   vecs[k].expDbg);
        end

        // Debug sweep: only r5, r8, r9, r31 were ever written
        for (int i = 0; i < 32; i++) begin
            logic [31:0] expVal;
            expVal = (i == 5) ? 32'h11 : (i == 8) ? 32'h1234 : (i == 9) ? 32'h22 :
                     (i == 31) ? 32'h1357 : 32'h0;
            applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd0, 5'd0, 5'(i));
            checkOutput($sformatf("dbg sweep r%0d", i), dbgA, expVal);
        end

        // Same-cycle read of r9 while overwriting it
        applyStimulus(1'b1, 5'd9, 32'h0000_0055, 1'b0, 32'h0, 5'd9, 5'd9, 5'd9);
        checkOutput("same-cycle A rs old",   read1A, 32'h0000_0022);
        checkOutput("same-cycle A dbg old",  dbgA,   32'h0000_0022);
        checkOutput("same-cycle B rs fwd",   read1B, 32'h0000_0055);
        checkOutput("same-cycle B rt fwd",   read2B, 32'h0000_0055);
        checkOutput("same-cycle B dbg old",  dbgB,   32'h0000_0022);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd9, 5'd9, 5'd9);
        checkOutput("same-cycle A rs new",   read1A, 32'h0000_0055);
        checkOutput("same-cycle B rs new",   read1B, 32'h0000_0055);

        // Forwarding on r31 prefers link data over write-back data
        applyStimulus(1'b1, 5'd31, 32'h0BAD_0BAD, 1'b1, 32'h0040_0020, 5'd31, 5'd0, 5'd31);
        checkOutput("link fwd B rs",  read1B, 32'h0040_0020);
        checkOutput("link fwd B rt0", read2B, 32'h0);
        checkOutput("link fwd A rs",  read1A, 32'h0000_1357);
        tick();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [4:0] wr;
            wr = 5'($urandom_range(0, 31));
            applyStimulus(1'($urandom_range(0, 1)), wr, $urandom,
                          ($urandom_range(0, 3) == 0), $urandom,
                          ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31)),
                          ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31)),
                          5'($urandom_range(0, 31)));
            checkAgainstModel($sformatf("rand %0d", n));
            tick();
        end

        // Asynchronous reset in mid-cycle with writes pending: no edge needed to clear
        #2;
        applyStimulus(1'b1, 5'd7, 32'h7777_7777, 1'b1, 32'h3131_3131, 5'd7, 5'd31, 5'd7);
        assertReset();
        #1;
        checkOutput("async rst A rs", read1A, 32'h0);
        checkOutput("async rst B rt", read2B, 32'h0);
        sweepZero("in rst", 1'b1);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        sweepZero("post rst", 1'b0);

        // First write after reset lands normally
        applyStimulus(1'b1, 5'd7, 32'h0000_0707, 1'b0, 32'h0, 5'd7, 5'd7, 5'd7);
        checkAgainstModel("post rst pre");
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd7, 5'd31, 5'd7);
        checkOutput("post rst r7", read1A, 32'h0000_0707);
        checkOutput("post rst r31", read2A, 32'h0);
        checkAgainstModel("post rst after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
